rmw_addr_issue: RTL and testbench
=================================

RMW_ADDR_ISSUE -- requirements
Module: rmw_addr_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: address queue entries, a power of two from 2 to 16.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset; the design has one clock, and reset asserted (low) clears all state immediately.
REQ-005 SHALL have port io_in_valid  input  1  upstream presents an address.
REQ-006 SHALL have port io_in_ready  output  1  the queue accepts an address this cycle.
REQ-007 SHALL have port io_in_addr  input  AW  address to enqueue.
REQ-008 SHALL have port io_addr  output  AW  address driven to the downstream read-modify-write memory stage.
REQ-009 SHALL have port io_addr_valid  output  1  io_addr holds a queued address.
REQ-010 SHALL have port io_addr_ready  input  1  downstream consumes io_addr this cycle.
REQ-011 SHALL have port io_issued  output  16  count of issued addresses, wrapping.
REQ-012 SHALL have port io_repeat  output  1  the address issued last cycle equals the one issued the cycle before.

Function
REQ-013 SHALL implement a DEPTH-entry circular FIFO with read/write pointers of log2(DEPTH) bits plus an occupancy count of log2(DEPTH)+1 bits.
REQ-014 SHALL enqueue on an edge where io_in_valid and io_in_ready are both 1.
REQ-015 SHALL dequeue on an edge where io_addr_valid and io_addr_ready are both 1.
REQ-016 SHALL drive io_in_ready = 1 when count < DEPTH, and also when count == DEPTH and a dequeue occurs the same cycle.
REQ-017 SHALL drive io_addr_valid = (count != 0) and io_addr = the head entry when count != 0.
REQ-018 SHALL hold io_addr at the last issued address when count == 0 (value 0 after reset), so the downstream memory index never floats.
REQ-019 SHALL, on simultaneous enqueue and dequeue, keep the count unchanged and advance both pointers.
REQ-020 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-021 SHALL add 0 to and ignore io_in_addr when io_in_ready is 0.
REQ-022 SHALL increment io_issued by 1 per dequeue, wrapping 0xFFFF to 0x0000.
REQ-023 SHALL register io_repeat on each dequeue as 1 if the dequeued address equals the previous dequeued address, else 0; it holds its value on cycles without a dequeue.
REQ-024 SHALL add zero combinational path from io_in_* to io_addr* unless the bypass of REQ-028 is compiled in.

Reset
REQ-025 SHALL, while reset is low, force count=0, both pointers=0, the held address=0, io_issued=0, io_repeat=0, and the stored previous-address=0.
REQ-026 SHALL produce these reset output values: io_addr_valid=0, io_addr=0, io_in_ready=1, io_issued=0, io_repeat=0.
REQ-027 SHALL discard queued entries on reset assertion mid-operation; the first enqueue after deassertion lands in entry 0.

Configuration
REQ-028 SHALL, with macro RMW_ADDR_ISSUE_BYPASS_EN defined, drive io_addr=io_in_addr and io_addr_valid=io_in_valid when count==0, and, if io_addr_ready is also 1, complete the transfer without writing the queue (zero latency).
REQ-029 SHALL, without RMW_ADDR_ISSUE_BYPASS_EN, give one-cycle minimum latency from enqueue to io_addr_valid.

Verification
REQ-030 Reset low mid-stream with 3 entries queued -> io_addr_valid=0, io_addr=0, io_issued=0 immediately, io_in_ready=1.
REQ-031 Enqueue 5,6,7,0 with io_addr_ready=0 -> io_in_ready=0 after the 4th; an attempt to enqueue 9 is not stored; release io_addr_ready -> issue order 5,6,7,0.
REQ-032 Full queue with simultaneous enqueue 9 and dequeue -> count stays 4 and 9 is issued last.
REQ-033 Issue 3,3,4 back-to-back -> io_repeat sequence 0,1,0, then io_issued=3.
REQ-034 Perform 65537 dequeues -> io_issued=1.
REQ-035 Empty queue, in_valid=1 with addr 2 and addr_ready=1 -> with BYPASS_EN, io_addr=2 the same cycle and count stays 0; without it, io_addr=2 and io_addr_valid=1 the next cycle.

Source files
------------

// File: rtl/rmw_addr_issue.sv
// Address queue feeding a read-modify-write memory stage: DEPTH-entry FIFO, issue counter, repeat flag.
// Optional zero-latency empty-queue bypass is compiled in with `define RMW_ADDR_ISSUE_BYPASS_EN.
module rmw_addr_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          io_in_valid,
  output logic          io_in_ready,
  input  logic [AW-1:0] io_in_addr,
  output logic [AW-1:0] io_addr,
  output logic          io_addr_valid,
  input  logic          io_addr_ready,
  output logic [15:0]   io_issued,
  output logic          io_repeat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] last_q, last_d;
  logic [15:0]   issued_q, issued_d;
  logic          repeat_q, repeat_d;

  logic          empty;
  logic          enq;
  logic          deq;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] head;

  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

`ifdef RMW_ADDR_ISSUE_BYPASS_EN
  // An empty queue forwards the upstream address straight through; with nothing offered it holds.
  assign io_addr_valid = empty ? io_in_valid : 1'b1;
  assign io_addr       = !empty ? head : (io_in_valid ? io_in_addr : last_q);
`else
  assign io_addr_valid = !empty;
  assign io_addr       = empty ? last_q : head;
`endif

  assign deq         = io_addr_valid & io_addr_ready;
  assign io_in_ready = (cnt_q != FULL) | deq;
  assign enq         = io_in_valid & io_in_ready;
  // A transfer taken while empty can only be a bypass, so it never touches the storage.
  assign wr_en       = enq & ~(empty & deq);
  assign rd_en       = deq & ~empty;

  assign io_issued = issued_q;
  assign io_repeat = repeat_q;

  always_comb begin
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    last_d   = last_q;
    issued_d = issued_q;
    repeat_d = repeat_q;
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (wr_en) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_en) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (deq) begin
      last_d   = io_addr;
      issued_d = issued_q + 16'd1;
      repeat_d = (io_addr == last_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      last_q   <= '0;
      issued_q <= '0;
      repeat_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      last_q   <= last_d;
      issued_q <= issued_d;
      repeat_q <= repeat_d;
    end
  end

  // Entry contents need no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= io_in_addr;
    end
  end

endmodule

// File: tb/tb_rmw_addr_issue.sv
// Scoreboard bench for rmw_addr_issue: accepted addresses are queued and compared as they issue.
module tb_rmw_addr_issue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [AW-1:0] io_in_addr;
  logic [AW-1:0] io_addr;
  logic          io_addr_valid;
  logic          io_addr_ready;
  logic [15:0]   io_issued;
  logic          io_repeat;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] sb [$];
  logic [AW-1:0] iss_log [$];
  logic          rep_log [$];
  logic [AW-1:0] last_m = '0;
  logic [15:0]   issued_m = '0;
  logic          rep_m = 1'b0;
  logic          pend_rep = 1'b0;
  int            ndeq = 0;

  logic          m_ev, m_dq, m_er, m_enq, m_empty;
  logic [AW-1:0] m_ea;

  rmw_addr_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_addr    (io_in_addr),
    .io_addr       (io_addr),
    .io_addr_valid (io_addr_valid),
    .io_addr_ready (io_addr_ready),
    .io_issued     (io_issued),
    .io_repeat     (io_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are stable at the falling edge; predict what the next rising edge does.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_rep) begin
        rep_log.push_back(io_repeat);
        pend_rep = 1'b0;
      end
      m_empty = (sb.size() == 0);
      m_ev    = !m_empty;
      m_ea    = m_empty ? last_m : sb[0];
`ifdef RMW_ADDR_ISSUE_BYPASS_EN
      if (m_empty && io_in_valid) begin
        m_ev = 1'b1;
        m_ea = io_in_addr;
      end
`endif
      chk("addr_valid", io_addr_valid, m_ev);
      chk("addr", io_addr, m_ea);
      chk("issued", io_issued, issued_m);
      chk("repeat", io_repeat, rep_m);
      m_dq  = m_ev && io_addr_ready;
      m_er  = (sb.size() < DEPTH) || m_dq;
      chk("in_ready", io_in_ready, m_er);
      m_enq = io_in_valid && m_er;
      if (m_dq) begin
        rep_m    = (m_ea == last_m);
        last_m   = m_ea;
        issued_m = issued_m + 16'd1;
        ndeq++;
        iss_log.push_back(m_ea);
        pend_rep = 1'b1;
        if (!m_empty) void'(sb.pop_front());
      end
      if (m_enq && !(m_empty && m_dq)) sb.push_back(io_in_addr);
    end
  end

  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic r);
    io_in_valid   = v;
    io_in_addr    = a;
    io_addr_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    iss_log.delete();
    rep_log.delete();
    last_m   = '0;
    issued_m = '0;
    rep_m    = 1'b0;
    pend_rep = 1'b0;
    ndeq     = 0;
  endtask

  // Called one step after a rising edge; reset lands mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    #2;
    rst_n         = 1'b0;
    io_in_valid   = 1'b0;
    io_addr_ready = 1'b0;
    model_clear();
    #1;
    chk("rst_addr_valid", io_addr_valid, 1'b0);
    chk("rst_addr", io_addr, '0);
    chk("rst_issued", io_issued, 16'd0);
    chk("rst_in_ready", io_in_ready, 1'b1);
    chk("rst_repeat", io_repeat, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    io_in_valid   = 1'b0;
    io_in_addr    = '0;
    io_addr_ready = 1'b0;
    #2;
    chk("init_addr_valid", io_addr_valid, 1'b0);
    chk("init_addr", io_addr, '0);
    chk("init_in_ready", io_in_ready, 1'b1);
    chk("init_issued", io_issued, 16'd0);
    chk("init_repeat", io_repeat, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, reject while full, then swap one in while one issues.
    cyc(1'b1, 32'd5, 1'b0);
    cyc(1'b1, 32'd6, 1'b0);
    cyc(1'b1, 32'd7, 1'b0);
    cyc(1'b1, 32'd0, 1'b0);
    chk("full_in_ready", io_in_ready, 1'b0);
    cyc(1'b1, 32'd9, 1'b0);
    iss_log.delete();
    cyc(1'b1, 32'd9, 1'b1);
    io_in_valid   = 1'b0;
    io_addr_ready = 1'b0;
    #1;
    chk("still_full", io_in_ready, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("order_len", iss_log.size(), 5);
    if (iss_log.size() == 5) begin
      chk("order0", iss_log[0], 32'd5);
      chk("order1", iss_log[1], 32'd6);
      chk("order2", iss_log[2], 32'd7);
      chk("order3", iss_log[3], 32'd0);
      chk("order4", iss_log[4], 32'd9);
    end

    // Reset with entries queued, then restart cleanly.
    cyc(1'b1, 32'd1, 1'b0);
    cyc(1'b1, 32'd2, 1'b0);
    cyc(1'b1, 32'd3, 1'b0);
    do_reset();
    cyc(1'b1, 32'hA5, 1'b0);
    io_in_valid = 1'b0;
    #1;
    chk("post_rst_head", io_addr, 32'hA5);
    chk("post_rst_valid", io_addr_valid, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("post_rst_empty", io_addr_valid, 1'b0);

    // Repeat flag on 3,3,4.
    do_reset();
    cyc(1'b1, 32'd3, 1'b1);
    cyc(1'b1, 32'd3, 1'b1);
    cyc(1'b1, 32'd4, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("rep_len", rep_log.size(), 3);
    if (rep_log.size() == 3) begin
      chk("rep0", rep_log[0], 1'b0);
      chk("rep1", rep_log[1], 1'b1);
      chk("rep2", rep_log[2], 1'b0);
    end
    chk("issued_3", io_issued, 16'd3);

    // Empty queue with an offered address.
    do_reset();
    io_in_valid   = 1'b1;
    io_in_addr    = 32'd2;
    io_addr_ready = 1'b1;
    #1;
`ifdef RMW_ADDR_ISSUE_BYPASS_EN
    chk("byp_same_valid", io_addr_valid, 1'b1);
    chk("byp_same_addr", io_addr, 32'd2);
`else
    chk("lat_same_valid", io_addr_valid, 1'b0);
`endif
    @(posedge clk);
    #1;
    io_in_valid = 1'b0;
    #1;
`ifdef RMW_ADDR_ISSUE_BYPASS_EN
    chk("byp_next_valid", io_addr_valid, 1'b0);
    chk("byp_next_addr", io_addr, 32'd2);
`else
    chk("lat_next_valid", io_addr_valid, 1'b1);
    chk("lat_next_addr", io_addr, 32'd2);
`endif
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 1'b0);

    // Random traffic over a small address range so repeats occur.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Issue counter wrap.
    do_reset();
    for (int i = 0; i < 70000 && ndeq < 65537; i++) cyc(1'b1, AW'(i % 5), 1'b1);
    io_in_valid   = 1'b0;
    io_addr_ready = 1'b0;
    chk("wrap_deq_count", ndeq, 65537);
    #1;
    chk("issued_wrap", io_issued, 16'd1);
    cyc(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
